// File: rtl/sm83_mcycle_seq.sv
`default_nettype none
// ============================================================================
//  Module      : sm83_mcycle_seq
//  Description : Machine-cycle sequencer for the sm83 core. Splits each
//                M-cycle into T_PER_M T-states and runs a FETCH M-cycle
//                followed by m_len EXECUTE M-cycles, with memory-wait
//                stretching in the last T-state and HALT/wake handling.
//                Optional macro SM83_MCYCLE_CNT_EN adds a free-running
//                32-bit M-cycle counter output (mcycle_cnt).
//  Revision    : 1.0  initial release
// ============================================================================
module sm83_mcycle_seq #(
    parameter int T_PER_M = 4,
    parameter int MAX_M   = 6,
    parameter int TW      = $clog2(T_PER_M),
    parameter int MW      = $clog2(MAX_M)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic [MW-1:0] m_len,
    input  logic          halt_req,
    input  logic          wake,
    output logic          fetch_cycle,
    output logic          execute_cycle,
    output logic [TW-1:0] t_state,
    output logic [MW-1:0] m_idx,
    output logic          m_end,
    output logic          instr_done,
    output logic          len_err,
`ifdef SM83_MCYCLE_CNT_EN
    output logic [31:0]   mcycle_cnt,
`endif
    output logic          halted
);

    localparam logic [TW-1:0] T_LAST  = TW'(T_PER_M - 1);
    localparam logic [MW-1:0] LEN_MAX = MW'(MAX_M - 1);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [TW-1:0] next_t;
    logic [MW-1:0] next_m;
    logic [MW-1:0] len;
    logic [MW-1:0] next_len;
    logic          next_done;
    logic          next_err;
    logic          len_over;
    logic [MW-1:0] len_sat;

    assign fetch_cycle   = (state == ST_FETCH);
    assign execute_cycle = (state == ST_EXEC);
    assign halted        = (state == ST_HALT);

    // Stall only counts in the last T-state; HALT never ends an M-cycle.
    assign m_end = (t_state == T_LAST) && !stall && (state != ST_HALT);

    // Over-long lengths from the decoder are clamped to the largest legal value.
    assign len_over = (m_len > LEN_MAX);
    assign len_sat  = len_over ? LEN_MAX : m_len;

    // State register plus T/M counters, latched length and one-shot pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_FETCH;
            t_state    <= '0;
            m_idx      <= '0;
            len        <= '0;
            instr_done <= 1'b0;
            len_err    <= 1'b0;
        end else begin
            state      <= next_state;
            t_state    <= next_t;
            m_idx      <= next_m;
            len        <= next_len;
            instr_done <= next_done;
            len_err    <= next_err;
        end
    end

    // Next-state and counter update; the final m_end of an instruction samples halt_req.
    always_comb begin
        next_state = state;
        next_t     = t_state;
        next_m     = m_idx;
        next_len   = len;
        next_done  = 1'b0;
        next_err   = 1'b0;

        if (state != ST_HALT) begin
            if (m_end) begin
                next_t = '0;
            end else if (t_state != T_LAST) begin
                next_t = t_state + TW'(1);
            end
        end

        case (state)
            ST_FETCH: begin
                if (m_end) begin
                    next_len = len_sat;
                    next_err = len_over;
                    if (len_sat == '0) begin
                        next_done  = 1'b1;
                        next_m     = '0;
                        next_state = halt_req ? ST_HALT : ST_FETCH;
                    end else begin
                        next_m     = MW'(1);
                        next_state = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                if (m_end) begin
                    if (m_idx < len) begin
                        next_m = m_idx + MW'(1);
                    end else begin
                        next_done  = 1'b1;
                        next_m     = '0;
                        next_state = halt_req ? ST_HALT : ST_FETCH;
                    end
                end
            end
            ST_HALT: begin
                next_t = '0;
                next_m = '0;
                if (wake) begin
                    next_state = ST_FETCH;
                end
            end
            default: begin
                next_state = ST_FETCH;
                next_t     = '0;
                next_m     = '0;
            end
        endcase
    end

`ifdef SM83_MCYCLE_CNT_EN
    // Counts completed M-cycles; m_end is never high in HALT so it holds there.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcycle_cnt <= '0;
        end else if (m_end) begin
            mcycle_cnt <= mcycle_cnt + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sm83_mcycle_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sm83_mcycle_seq
//  Description : Directed self-checking bench for sm83_mcycle_seq
//                (T_PER_M=4, MAX_M=6).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sm83_mcycle_seq;

    logic       clk;
    logic       rst_n;
    logic       stall;
    logic [2:0] m_len;
    logic       halt_req;
    logic       wake;
    logic       fetch_cycle;
    logic       execute_cycle;
    logic [1:0] t_state;
    logic [2:0] m_idx;
    logic       m_end;
    logic       instr_done;
    logic       len_err;
    logic       halted;
`ifdef SM83_MCYCLE_CNT_EN
    logic [31:0] mcycle_cnt;
`endif

    int vectors;
    int miscompares;

    sm83_mcycle_seq #(.T_PER_M(4), .MAX_M(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .m_len        (m_len),
        .halt_req     (halt_req),
        .wake         (wake),
        .fetch_cycle  (fetch_cycle),
        .execute_cycle(execute_cycle),
        .t_state      (t_state),
        .m_idx        (m_idx),
        .m_end        (m_end),
        .instr_done   (instr_done),
        .len_err      (len_err),
`ifdef SM83_MCYCLE_CNT_EN
        .mcycle_cnt   (mcycle_cnt),
`endif
        .halted       (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; stall = 1'b0; m_len = 3'd0;
        halt_req = 1'b0; wake = 1'b0;
        vectors = 0; miscompares = 0;

        // Reset values
        repeat (2) next_cycle();
        #2;
        check("rst_fetch", fetch_cycle, 1);
        check("rst_exec", execute_cycle, 0);
        check("rst_t", t_state, 0);
        check("rst_m", m_idx, 0);
        check("rst_halted", halted, 0);
        check("rst_done", instr_done, 0);
        check("rst_err", len_err, 0);
`ifdef SM83_MCYCLE_CNT_EN
        check("rst_cnt", mcycle_cnt, 0);
`endif
        next_cycle();
        rst_n = 1'b1;

        // 1: m_len=0, back-to-back fetches
        for (int k = 0; k < 8; k++) begin
            m_len = 3'd0;
            #2;
            check("t1_fetch", fetch_cycle, 1);
            check("t1_exec", execute_cycle, 0);
            check("t1_t", t_state, k % 4);
            check("t1_mend", m_end, (k % 4 == 3) ? 1 : 0);
            check("t1_done", instr_done, (k % 4 == 0 && k > 0) ? 1 : 0);
            next_cycle();
        end

        // 2: m_len=2 -> FETCH + two EXEC M-cycles
        for (int c = 0; c < 12; c++) begin
            m_len = 3'd2;
            #2;
            check("t2_fetch", fetch_cycle, (c < 4) ? 1 : 0);
            check("t2_exec", execute_cycle, (c >= 4) ? 1 : 0);
            check("t2_m", m_idx, (c < 4) ? 0 : (c < 8) ? 1 : 2);
            check("t2_t", t_state, c % 4);
            check("t2_done", instr_done, (c == 0) ? 1 : 0);
            next_cycle();
        end

        // 3: stall stretches the EXEC M-cycle to 7 clks; halt_req during stall is not sampled
        for (int d = 0; d < 11; d++) begin
            m_len    = 3'd1;
            stall    = (d == 5 || d == 7 || d == 8 || d == 9);
            halt_req = (d >= 7 && d <= 9);
            #2;
            check("t3_t", t_state, (d < 4) ? d : (d < 7) ? d - 4 : 3);
            check("t3_mend", m_end, (d == 3 || d == 10) ? 1 : 0);
            check("t3_exec", execute_cycle, (d >= 4) ? 1 : 0);
            check("t3_done", instr_done, (d == 0) ? 1 : 0);
            next_cycle();
        end
        stall = 1'b0; halt_req = 1'b0;

        // 4: HALT entry, quiet period, wake; then halt + wake together
        for (int e = 0; e < 25; e++) begin
            m_len    = (e < 19) ? 3'd1 : 3'd0;
            halt_req = (e >= 3 && e <= 17) || (e >= 22);
            wake     = (e == 18 || e == 24);
            stall    = (e >= 9 && e <= 17);
            #2;
            check("t4_halted", halted, ((e >= 8 && e <= 18) || e >= 23) ? 1 : 0);
            check("t4_fetch", fetch_cycle, (e < 4 || (e >= 19 && e <= 22)) ? 1 : 0);
            check("t4_exec", execute_cycle, (e >= 4 && e <= 7) ? 1 : 0);
            check("t4_t", t_state, (e < 4) ? e : (e < 8) ? e - 4 :
                                   (e >= 19 && e <= 22) ? e - 19 : 0);
            check("t4_m", m_idx, (e >= 4 && e <= 7) ? 1 : 0);
            check("t4_mend", m_end, (e == 3 || e == 7 || e == 22) ? 1 : 0);
            check("t4_done", instr_done, (e == 0 || e == 8 || e == 23) ? 1 : 0);
            next_cycle();
        end
        halt_req = 1'b0; wake = 1'b0; stall = 1'b0;

        // 5: m_len=7 clamps to 5 EXEC M-cycles with one len_err pulse
        for (int f = 0; f < 24; f++) begin
            m_len = (f < 4) ? 3'd7 : 3'd0;
            #2;
            check("t5_halted", halted, 0);
            check("t5_exec", execute_cycle, (f >= 4) ? 1 : 0);
            check("t5_m", m_idx, (f < 4) ? 0 : (f - 4) / 4 + 1);
            check("t5_err", len_err, (f == 4) ? 1 : 0);
            check("t5_done", instr_done, 0);
            next_cycle();
        end

        // 6: reset in EXEC m_idx=2, t_state=2 aborts without instr_done
        for (int g = 0; g < 16; g++) begin
            m_len = (g < 4) ? 3'd3 : 3'd0;
            rst_n = (g != 10);
            #2;
            if (g == 0) check("t6_done_prev", instr_done, 1);
            if (g == 10) begin
                check("t6_pre_m", m_idx, 2);
                check("t6_pre_t", t_state, 2);
            end
            if (g >= 11) begin
                check("t6_fetch", fetch_cycle, 1);
                check("t6_t", t_state, (g - 11) % 4);
                check("t6_m", m_idx, 0);
                check("t6_done", instr_done, (g == 15) ? 1 : 0);
`ifdef SM83_MCYCLE_CNT_EN
                check("t6_cnt", mcycle_cnt, (g == 15) ? 1 : 0);
`endif
            end
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
